// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and opcode encoding for the alu_regfile datapath
package alu_pkg;

    localparam int DATA_W   = 8;
    localparam int REG_AW   = 2;
    localparam int NUM_REGS = 4;

    // Opcodes 6..14 are decoded by the control FSM; the ALU outputs zero for them
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLL  = 4'd4,
        OP_SRL  = 4'd5,
        OP_LDI  = 4'd6,
        OP_ADDI = 4'd7,
        OP_LD   = 4'd8,
        OP_ST   = 4'd9,
        OP_BNE  = 4'd10,
        OP_BEQ  = 4'd11,
        OP_J    = 4'd12,
        OP_HALT = 4'd13,
        OP_EXT  = 4'd14
    } opcode_e;

endpackage

// File: rtl/alu_regfile_if.sv
// alu_regfile_if: control-to-datapath bus (register addresses, write port, opcode, results, flags)
interface alu_regfile_if;
    import alu_pkg::*;

    logic              reg_write;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] rs_addr;
    logic [DATA_W-1:0] write_data;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] alu_result;
    logic              shift_flag_c;
    logic              carry_flag_c;
    logic              shift_flag;
    logic              carry_flag;

    modport master (
        output reg_write, rd_addr, rs_addr, write_data, opcode,
        input  rd_data, rs_data, alu_result, shift_flag_c, carry_flag_c, shift_flag, carry_flag
    );

    modport slave (
        input  reg_write, rd_addr, rs_addr, write_data, opcode,
        output rd_data, rs_data, alu_result, shift_flag_c, carry_flag_c, shift_flag, carry_flag
    );

endinterface

// File: rtl/alu_regfile_regfile.sv
// alu_regfile_regfile: 4x8 register file, two combinational read ports, one sync write port;
// REGFILE_WRITE_BYPASS_EN forwards write data to a read port addressing the written register
module alu_regfile_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [REG_AW-1:0] ra_i,
    input  logic [REG_AW-1:0] rb_i,
    output logic [DATA_W-1:0] ra_data_o,
    output logic [DATA_W-1:0] rb_data_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Storage: reset clears every register and wins over a simultaneous write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    assign ra_data_o = (we_i && ra_i == wa_i) ? wd_i : regs_q[ra_i];
    assign rb_data_o = (we_i && rb_i == wa_i) ? wd_i : regs_q[rb_i];
`else
    assign ra_data_o = regs_q[ra_i];
    assign rb_data_o = regs_q[rb_i];
`endif

endmodule

// File: rtl/alu_regfile.sv
// alu_regfile: register file plus 4-bit-opcode ALU with registered shift/carry flags
// (optional REGFILE_WRITE_BYPASS_EN enables same-cycle write forwarding in the register file)
module alu_regfile
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    alu_regfile_if.slave bus
);

    logic [DATA_W-1:0] a, b;
    logic [DATA_W:0]   sum, diff, sll_w, srl_w;
    logic [2:0]        n;
    logic [DATA_W-1:0] result_d;
    logic              shift_d, carry_d;
    logic              shift_flag_q, carry_flag_q;

    alu_regfile_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (bus.reg_write),
        .wa_i      (bus.rd_addr),
        .wd_i      (bus.write_data),
        .ra_i      (bus.rd_addr),
        .rb_i      (bus.rs_addr),
        .ra_data_o (a),
        .rb_data_o (b)
    );

    // Ninth bit of the widened shifts is the last bit shifted out (zero when n == 0)
    assign n     = b[2:0];
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign sll_w = {1'b0, a} << n;
    assign srl_w = {a, 1'b0} >> n;

    // ALU result and combinational flags; unhandled opcodes give zero result and flags
    always_comb begin
        result_d = '0;
        shift_d  = 1'b0;
        carry_d  = 1'b0;
        case (bus.opcode)
            OP_ADD: begin result_d = sum[DATA_W-1:0];  carry_d = sum[DATA_W];  end
            OP_SUB: begin result_d = diff[DATA_W-1:0]; carry_d = diff[DATA_W]; end
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_SLL: begin result_d = sll_w[DATA_W-1:0]; shift_d = sll_w[DATA_W]; end
            OP_SRL: begin result_d = srl_w[DATA_W:1];   shift_d = srl_w[0];      end
            default: ;
        endcase
    end

    // Flags capture the current operation every edge, independent of reg_write
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_flag_q <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            shift_flag_q <= shift_d;
            carry_flag_q <= carry_d;
        end
    end

    assign bus.rd_data      = a;
    assign bus.rs_data      = b;
    assign bus.alu_result   = result_d;
    assign bus.shift_flag_c = shift_d;
    assign bus.carry_flag_c = carry_d;
    assign bus.shift_flag   = shift_flag_q;
    assign bus.carry_flag   = carry_flag_q;

endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed vector table, corner sequences and randomized model check for alu_regfile
module tb_alu_regfile;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    int   model [4];

    alu_regfile_if bus ();

    alu_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va, vb;
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [7:0] res;
        logic       sh, ca;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference ALU from arithmetic rules: returns {shift, carry, result}
    function automatic logic [9:0] ref_alu(input int op, input int a, input int b);
        int n, r, s, c;
        n = b % 8; r = 0; s = 0; c = 0;
        case (op)
            0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: begin r = (a * (1 << n)) % 256; s = (n > 0) ? (a >> (8 - n)) % 2 : 0; end
            5: begin r = a >> n; s = (n > 0) ? (a >> (n - 1)) % 2 : 0; end
            default: ;
        endcase
        return {1'(s), 1'(c), 8'(r)};
    endfunction

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        bus.reg_write = 1'b1; bus.rd_addr = a; bus.write_data = v;
        @(posedge clk); #1;
        bus.reg_write = 1'b0;
        model[a] = v;
    endtask

    initial begin
        logic [9:0] e;
        logic [7:0] av, bv;
        int op, ra, rb, we, wd;
        vecs[0]  = '{8'hF0, 8'h20, 4'd0,  2'd1, 2'd2, 8'h10, 1'b0, 1'b1};
        vecs[1]  = '{8'h05, 8'h07, 4'd1,  2'd1, 2'd2, 8'hFE, 1'b0, 1'b1};
        vecs[2]  = '{8'h05, 8'h07, 4'd1,  2'd2, 2'd1, 8'h02, 1'b0, 1'b0};
        vecs[3]  = '{8'h81, 8'h01, 4'd4,  2'd1, 2'd2, 8'h02, 1'b1, 1'b0};
        vecs[4]  = '{8'h81, 8'h01, 4'd5,  2'd1, 2'd2, 8'h40, 1'b1, 1'b0};
        vecs[5]  = '{8'h81, 8'h08, 4'd4,  2'd1, 2'd2, 8'h81, 1'b0, 1'b0};
        vecs[6]  = '{8'h81, 8'h08, 4'd5,  2'd1, 2'd2, 8'h81, 1'b0, 1'b0};
        vecs[7]  = '{8'hF0, 8'h3C, 4'd2,  2'd1, 2'd2, 8'h30, 1'b0, 1'b0};
        vecs[8]  = '{8'hF0, 8'h3C, 4'd3,  2'd1, 2'd2, 8'hFC, 1'b0, 1'b0};
        vecs[9]  = '{8'h12, 8'h34, 4'd13, 2'd1, 2'd2, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'h12, 8'h34, 4'd15, 2'd1, 2'd2, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{8'h80, 8'h80, 4'd0,  2'd1, 2'd1, 8'h00, 1'b0, 1'b1};
        vecs[12] = '{8'h88, 8'h05, 4'd4,  2'd1, 2'd2, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{8'h88, 8'hFD, 4'd5,  2'd1, 2'd2, 8'h04, 1'b0, 1'b0};

        reset = 1'b1;
        bus.reg_write = 1'b0; bus.rd_addr = '0; bus.rs_addr = '0;
        bus.write_data = '0; bus.opcode = 4'd0;
        for (int i = 0; i < 4; i++) model[i] = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state of every register and both flags
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr = 2'(i); bus.rs_addr = 2'(3 - i);
            #1;
            chk("reset_rd", bus.rd_data, 0);
            chk("reset_rs", bus.rs_data, 0);
        end
        chk("reset_shift_flag", bus.shift_flag, 0);
        chk("reset_carry_flag", bus.carry_flag, 0);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            wr(2'd1, vecs[i].va);
            if (vecs[i].rd != vecs[i].rs) wr(2'd2, vecs[i].vb);
            bus.opcode = vecs[i].op; bus.rd_addr = vecs[i].rd; bus.rs_addr = vecs[i].rs;
            @(negedge clk);
            chk($sformatf("vec%0d_result", i), bus.alu_result, vecs[i].res);
            chk($sformatf("vec%0d_shift_c", i), bus.shift_flag_c, vecs[i].sh);
            chk($sformatf("vec%0d_carry_c", i), bus.carry_flag_c, vecs[i].ca);
            chk($sformatf("vec%0d_rd_data", i), bus.rd_data, (vecs[i].rd == 2'd1) ? vecs[i].va : vecs[i].vb);
            chk($sformatf("vec%0d_rs_data", i), bus.rs_data, (vecs[i].rs == 2'd1) ? vecs[i].va : vecs[i].vb);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_shift_flag", i), bus.shift_flag, vecs[i].sh);
            chk($sformatf("vec%0d_carry_flag", i), bus.carry_flag, vecs[i].ca);
        end

        // Same-cycle write/read of r3
        wr(2'd3, 8'h11);
        bus.opcode = 4'd2;
        bus.reg_write = 1'b1; bus.rd_addr = 2'd3; bus.rs_addr = 2'd3; bus.write_data = 8'hAA;
        @(negedge clk);
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("same_cycle_rd", bus.rd_data, 8'hAA);
        chk("same_cycle_rs", bus.rs_data, 8'hAA);
`else
        chk("same_cycle_rd", bus.rd_data, 8'h11);
        chk("same_cycle_rs", bus.rs_data, 8'h11);
`endif
        @(posedge clk); #1;
        bus.reg_write = 1'b0; model[3] = 8'hAA;
        chk("after_write_rd", bus.rd_data, 8'hAA);
        chk("after_write_rs", bus.rs_data, 8'hAA);

        // Flags set, then reset together with a write to r0
        wr(2'd0, 8'h11);
        wr(2'd1, 8'hFF);
        bus.opcode = 4'd0; bus.rd_addr = 2'd1; bus.rs_addr = 2'd1;
        @(posedge clk); #1;
        chk("pre_reset_carry_flag", bus.carry_flag, 1);
        reset = 1'b1; bus.reg_write = 1'b1; bus.rd_addr = 2'd0; bus.write_data = 8'h55;
        @(posedge clk); #1;
        reset = 1'b0; bus.reg_write = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 0;
        bus.rs_addr = 2'd1;
        #1;
        chk("reset_write_r0", bus.rd_data, 0);
        chk("reset_r1", bus.rs_data, 0);
        chk("reset_carry_flag2", bus.carry_flag, 0);
        chk("reset_shift_flag2", bus.shift_flag, 0);
        bus.opcode = 4'd13;
        #1;
        chk("halt_result", bus.alu_result, 0);
        chk("halt_flags", {bus.shift_flag_c, bus.carry_flag_c}, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 15); ra = $urandom_range(0, 3); rb = $urandom_range(0, 3);
            we = $urandom_range(0, 1); wd = $urandom_range(0, 255);
            bus.opcode = 4'(op); bus.rd_addr = 2'(ra); bus.rs_addr = 2'(rb);
            bus.reg_write = 1'(we); bus.write_data = 8'(wd);
            @(negedge clk);
            av = 8'(model[ra]); bv = 8'(model[rb]);
`ifdef REGFILE_WRITE_BYPASS_EN
            if (we == 1) begin
                av = 8'(wd);
                if (rb == ra) bv = 8'(wd);
            end
`endif
            e = ref_alu(op, av, bv);
            chk("rand_rd_data", bus.rd_data, av);
            chk("rand_rs_data", bus.rs_data, bv);
            chk("rand_result", bus.alu_result, e[7:0]);
            chk("rand_carry_c", bus.carry_flag_c, e[8]);
            chk("rand_shift_c", bus.shift_flag_c, e[9]);
            @(posedge clk); #1;
            if (we == 1) model[ra] = wd;
            chk("rand_carry_flag", bus.carry_flag, e[8]);
            chk("rand_shift_flag", bus.shift_flag, e[9]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
